// File: rtl/int_to_floating_point_if.sv
// rtl/int_to_floating_point_if.sv - request/result bundle of the integer-to-float converter
interface int_to_floating_point_if #(
  parameter int int_size  = 64,
  parameter int precision = 32
);
  logic [int_size-1:0]  i_int;
  logic [1:0]           i_conv;
  logic                 i_start;
  logic [precision-1:0] o_float;
  logic                 o_inexact_flag;
  logic                 o_busy;
  logic                 o_done;

  modport master (
    output i_int, i_conv, i_start,
    input  o_float, o_inexact_flag, o_busy, o_done
  );

  modport slave (
    input  i_int, i_conv, i_start,
    output o_float, o_inexact_flag, o_busy, o_done
  );
endinterface

// File: rtl/int_to_floating_point.sv
// rtl/int_to_floating_point.sv - signed integer to IEEE-754 float, fixed capture/normalize/round sequence
module int_to_floating_point #(
  parameter int int_size      = 64,
  parameter int mantissa_size = 23,
  parameter int exponent_size = 8,
  parameter int precision     = 1 + exponent_size + mantissa_size,
  parameter int exp_bias      = (1 << (exponent_size - 1)) - 1
) (
  input  logic                    i_clk,
  input  logic                    i_reset,
  int_to_floating_point_if.slave  bus
);
  localparam int LZW  = $clog2(int_size + 1);
  localparam int KW   = mantissa_size + 1;
  // Right-pad narrow integers so guard and sticky always have at least one bit each.
  localparam int EXTW = (int_size > mantissa_size + 3) ? int_size : mantissa_size + 3;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    NORM  = 2'b01,
    ROUND = 2'b10,
    DONE  = 2'b11
  } state_t;

  state_t                   r_state;
  state_t                   w_next;
  logic                     r_sign;
  logic [int_size-1:0]      r_mag;
  logic [1:0]               r_conv;
  logic [exponent_size-1:0] r_exp;
  logic [precision-1:0]     r_float;
  logic                     r_inexact;

  logic [LZW-1:0]           w_lzc;
  logic [int_size-1:0]      w_norm;
  logic [EXTW-1:0]          w_ext;
  logic [KW-1:0]            w_kept;
  logic                     w_guard;
  logic                     w_sticky;
  logic                     w_inexact;
  logic                     w_round_up;
  logic [KW:0]              w_sum;
  logic [exponent_size-1:0] w_exp_field;
  logic [mantissa_size-1:0] w_frac;
  logic [precision-1:0]     w_packed;

  always_ff @(posedge i_clk) begin
    if (i_reset) r_state <= IDLE;
    else         r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (bus.i_start) w_next = NORM;
      NORM:    w_next = ROUND;
      ROUND:   w_next = DONE;
      default: w_next = IDLE;
    endcase
  end

  // Highest set bit wins; an all-zero magnitude reports int_size.
  always_comb begin
    w_lzc = LZW'(int_size);
    for (int i = 0; i < int_size; i++) begin
      if (r_mag[i]) w_lzc = LZW'(int_size - 1 - i);
    end
  end

  assign w_norm    = r_mag << w_lzc;
  assign w_ext     = EXTW'(r_mag) << (EXTW - int_size);
  assign w_kept    = w_ext[EXTW-1 -: KW];
  assign w_guard   = w_ext[EXTW-KW-1];
  assign w_sticky  = |w_ext[EXTW-KW-2:0];
  assign w_inexact = w_guard | w_sticky;

  always_comb begin
    w_round_up = 1'b0;
    case (r_conv)
      2'b01:   w_round_up = r_sign & w_inexact;
      2'b10:   w_round_up = ~r_sign & w_inexact;
      2'b11:   w_round_up = w_guard & (w_sticky | w_kept[0]);
      default: w_round_up = 1'b0;
    endcase
  end

  // A carry out of the significand means it wrapped to 1.000..., so bump the exponent.
  assign w_sum       = {1'b0, w_kept} + {{KW{1'b0}}, w_round_up};
  assign w_exp_field = r_exp + exponent_size'(exp_bias) + {{(exponent_size-1){1'b0}}, w_sum[KW]};
  assign w_frac      = w_sum[KW] ? '0 : w_sum[mantissa_size-1:0];
  assign w_packed    = r_mag[int_size-1] ? {r_sign, w_exp_field, w_frac} : '0;

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_sign    <= 1'b0;
      r_mag     <= '0;
      r_conv    <= 2'b00;
      r_exp     <= '0;
      r_float   <= '0;
      r_inexact <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (bus.i_start) begin
            r_sign <= bus.i_int[int_size-1];
            r_mag  <= bus.i_int[int_size-1] ? -bus.i_int : bus.i_int;
            r_conv <= bus.i_conv;
          end
        end
        NORM: begin
          r_mag <= w_norm;
          r_exp <= exponent_size'(int_size - 1) - exponent_size'(w_lzc);
        end
        ROUND: begin
          r_float   <= w_packed;
          r_inexact <= r_mag[int_size-1] & w_inexact;
        end
        default: ;
      endcase
    end
  end

  assign bus.o_float        = r_float;
  assign bus.o_inexact_flag = r_inexact;
  assign bus.o_busy         = (r_state != IDLE);
  assign bus.o_done         = (r_state == DONE);
endmodule

// File: tb/tb_int_to_floating_point.sv
// tb/tb_int_to_floating_point.sv - directed bench for int_to_floating_point
module tb_int_to_floating_point;
  logic clk = 1'b0;
  logic reset;
  int   n_cmp = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  int_to_floating_point_if #(.int_size(64), .precision(32)) bus ();

  int_to_floating_point dut (
    .i_clk   (clk),
    .i_reset (reset),
    .bus     (bus)
  );

  typedef struct {
    logic [63:0] v;
    logic [1:0]  m;
    logic [31:0] f;
    logic        x;
  } vec_t;

  // Drives one request, scrambles the inputs after acceptance, returns result and timing.
  task automatic do_conv(input logic [63:0] val, input logic [1:0] mode,
                         output logic [31:0] f, output logic inx,
                         output int lat, output int width, output logic busy_after);
    @(negedge clk);
    bus.i_int   = val;
    bus.i_conv  = mode;
    bus.i_start = 1'b1;
    @(posedge clk); #1;
    bus.i_start = 1'b0;
    bus.i_int   = 64'hA5A5_5A5A_C3C3_3C3C;
    bus.i_conv  = ~mode;
    lat = 0;
    for (int c = 1; c <= 8; c++) begin
      @(posedge clk); #1;
      if (bus.o_done) begin
        lat = c;
        break;
      end
    end
    f     = bus.o_float;
    inx   = bus.o_inexact_flag;
    width = 0;
    busy_after = 1'b1;
    if (lat != 0) begin
      @(posedge clk); #1;
      width      = bus.o_done ? 2 : 1;
      busy_after = bus.o_busy;
    end
  endtask

  task automatic run_table(input string name, input vec_t tbl[]);
    logic [31:0] f;
    logic        x, b;
    int          lat, w;
    foreach (tbl[i]) begin
      do_conv(tbl[i].v, tbl[i].m, f, x, lat, w, b);
      n_cmp++;
      if (lat !== 2) begin
        n_err++;
        $display("FAIL %s[%0d] latency: got %0d expected 2", name, i, lat);
      end
      n_cmp++;
      if (f !== tbl[i].f) begin
        n_err++;
        $display("FAIL %s[%0d] float: got %h expected %h", name, i, f, tbl[i].f);
      end
      n_cmp++;
      if (x !== tbl[i].x) begin
        n_err++;
        $display("FAIL %s[%0d] inexact: got %b expected %b", name, i, x, tbl[i].x);
      end
      n_cmp++;
      if (w !== 1 || b !== 1'b0) begin
        n_err++;
        $display("FAIL %s[%0d] done_width/busy: got %0d/%b expected 1/0", name, i, w, b);
      end
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    bus.i_start = 1'b1;
    bus.i_int   = 64'd5;
    repeat (3) @(posedge clk);
    #1;
    n_cmp++;
    if ({bus.o_float, bus.o_inexact_flag, bus.o_done, bus.o_busy} !== 35'd0) begin
      n_err++;
      $display("FAIL reset outputs: got %h/%b/%b/%b expected 0/0/0/0",
               bus.o_float, bus.o_inexact_flag, bus.o_done, bus.o_busy);
    end
    bus.i_start = 1'b0;
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_basic();
    vec_t t[] = '{
      '{64'd1,                   2'b00, 32'h3F80_0000, 1'b0},
      '{64'hFFFF_FFFF_FFFF_FFFF, 2'b00, 32'hBF80_0000, 1'b0},
      '{64'h8000_0000_0000_0000, 2'b11, 32'hDF00_0000, 1'b0}
    };
    run_table("basic", t);
  endtask

  task automatic test_zero();
    vec_t t[] = '{
      '{64'd0, 2'b00, 32'h0, 1'b0},
      '{64'd0, 2'b01, 32'h0, 1'b0},
      '{64'd0, 2'b10, 32'h0, 1'b0},
      '{64'd0, 2'b11, 32'h0, 1'b0}
    };
    run_table("zero", t);
  endtask

  task automatic test_round_modes();
    vec_t t[] = '{
      '{64'd16777217,            2'b11, 32'h4B80_0000, 1'b1},
      '{64'd16777217,            2'b10, 32'h4B80_0001, 1'b1},
      '{64'd16777217,            2'b00, 32'h4B80_0000, 1'b1},
      '{64'd16777217,            2'b01, 32'h4B80_0000, 1'b1},
      '{64'hFFFF_FFFF_FEFF_FFFF, 2'b01, 32'hCB80_0001, 1'b1},
      '{64'hFFFF_FFFF_FEFF_FFFF, 2'b10, 32'hCB80_0000, 1'b1},
      '{64'hFFFF_FFFF_FEFF_FFFF, 2'b11, 32'hCB80_0000, 1'b1}
    };
    run_table("round", t);
  endtask

  task automatic test_carry();
    vec_t t[] = '{
      '{64'h1FF_FFFF, 2'b11, 32'h4C00_0000, 1'b1},
      '{64'h1FF_FFFF, 2'b00, 32'h4BFF_FFFF, 1'b1}
    };
    run_table("carry", t);
  endtask

  task automatic test_start_ignored();
    int cnt = 0;
    @(negedge clk);
    bus.i_int   = 64'd1;
    bus.i_conv  = 2'b00;
    bus.i_start = 1'b1;
    for (int c = 0; c < 12; c++) begin
      @(posedge clk); #1;
      if (c == 3) bus.i_start = 1'b0;
      if (bus.o_done) cnt++;
    end
    n_cmp++;
    if (cnt !== 1 || bus.o_busy !== 1'b0) begin
      n_err++;
      $display("FAIL start_ignored done_count/busy: got %0d/%b expected 1/0", cnt, bus.o_busy);
    end
  endtask

  task automatic test_reset_abort();
    logic [31:0] f;
    logic        x, b;
    int          lat, w, cnt;
    do_conv(64'd16777217, 2'b10, f, x, lat, w, b);
    n_cmp++;
    if (f !== 32'h4B80_0001 || x !== 1'b1) begin
      n_err++;
      $display("FAIL abort_setup: got %h/%b expected 4b800001/1", f, x);
    end
    @(negedge clk);
    bus.i_int   = 64'hFFFF_FFFF_FFFF_FFFF;
    bus.i_start = 1'b1;
    @(posedge clk); #1;
    bus.i_start = 1'b0;
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    n_cmp++;
    if ({bus.o_float, bus.o_inexact_flag, bus.o_done, bus.o_busy} !== 35'd0) begin
      n_err++;
      $display("FAIL abort outputs: got %h/%b/%b/%b expected 0/0/0/0",
               bus.o_float, bus.o_inexact_flag, bus.o_done, bus.o_busy);
    end
    cnt = 0;
    repeat (5) begin
      @(posedge clk); #1;
      if (bus.o_done) cnt++;
    end
    n_cmp++;
    if (cnt !== 0) begin
      n_err++;
      $display("FAIL abort no_done: got %0d done cycles expected 0", cnt);
    end
  endtask

  task automatic test_back_to_back();
    @(negedge clk);
    bus.i_int   = 64'd16777217;
    bus.i_conv  = 2'b10;
    bus.i_start = 1'b1;
    @(posedge clk); #1;
    bus.i_start = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    n_cmp++;
    if (bus.o_done !== 1'b1 || bus.o_float !== 32'h4B80_0001) begin
      n_err++;
      $display("FAIL b2b first: got %b/%h expected 1/4b800001", bus.o_done, bus.o_float);
    end
    @(posedge clk); #1;
    bus.i_int   = 64'hFFFF_FFFF_FFFF_FFFF;
    bus.i_conv  = 2'b00;
    bus.i_start = 1'b1;
    @(posedge clk); #1;
    bus.i_start = 1'b0;
    n_cmp++;
    if (bus.o_busy !== 1'b1) begin
      n_err++;
      $display("FAIL b2b accept busy: got %b expected 1", bus.o_busy);
    end
    repeat (2) @(posedge clk);
    #1;
    n_cmp++;
    if (bus.o_done !== 1'b1 || bus.o_float !== 32'hBF80_0000 || bus.o_inexact_flag !== 1'b0) begin
      n_err++;
      $display("FAIL b2b second: got %b/%h/%b expected 1/bf800000/0",
               bus.o_done, bus.o_float, bus.o_inexact_flag);
    end
    @(posedge clk); #1;
  endtask

  initial begin
    reset       = 1'b1;
    bus.i_start = 1'b0;
    bus.i_int   = '0;
    bus.i_conv  = 2'b00;
    test_reset();
    test_basic();
    test_zero();
    test_round_modes();
    test_carry();
    test_start_ignored();
    test_reset_abort();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
